// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states
// and a small op-classification helper.
package md_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIN  = 2'd2
   } md_state_e;

   // True for the ops that need the iterative datapath.
   function automatic logic is_iter_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   // True for the ops whose operands are two's complement.
   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Pipeline-side bundle for the multiply/divide unit.
// Handshake: a request (start=1) is accepted on the rising edge where
// busy=0 and flush=0; while busy=1 start is ignored (no queueing). done is a
// one-cycle pulse in the cycle hi/lo first show a MULT/DIV result. MTHI/MTLO
// complete at the accepting edge and never raise busy or done.
interface mul_div_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, flush, input busy, done, hi, lo);
   modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/md_iter_core.sv
// Shared radix-2 iteration datapath: a 2*WIDTH shift register and one
// WIDTH+1-bit adder/subtractor. mode=0 runs shift-add multiply (right
// shift), mode=1 runs restoring shift-subtract divide (left shift).
module md_iter_core #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic               mode,
   input  logic [WIDTH-1:0]   lo_in,
   input  logic [WIDTH-1:0]   opd_in,
   output logic [2*WIDTH-1:0] acc_nxt
);

   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH-1:0]   opd_q;
   logic [WIDTH:0]     x, y, s;
   logic               ge;

   // One step of the selected algorithm; x/y feed the single adder.
   always_comb begin
      y       = {1'b0, opd_q};
      x       = '0;
      s       = '0;
      ge      = 1'b0;
      acc_nxt = acc_q;
      if (mode) begin
         // Partial remainder shifted left by one with next dividend bit.
         x  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
         s  = x - y;
         // x[WIDTH] set means x exceeds any divisor (covers divisor 0).
         ge = x[WIDTH] | ~s[WIDTH];
         acc_nxt = ge ? {s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                      : {x[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
         x = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
         s = x + y;
         acc_nxt = acc_q[0] ? {s, acc_q[WIDTH-1:1]} : {x, acc_q[WIDTH-1:1]};
      end
   end

   // Load operands on accept, advance one step per running cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         opd_q <= '0;
      end else if (load) begin
         acc_q <= {{WIDTH{1'b0}}, lo_in};
         opd_q <= opd_in;
      end else if (step) begin
         acc_q <= acc_nxt;
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with architectural HI/LO.
// Operands are reduced to magnitudes on accept; signs are reapplied when the
// final step is written into hi/lo.
module mul_div_unit
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   mul_div_unit_if.slave  bus,
   output md_state_e      state_dbg
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               is_mul_q, q_neg_q, r_neg_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               can_start, accept_iter, accept_mt, last_step;
   logic               a_neg, b_neg, is_mul_op;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [2*WIDTH-1:0] acc_nxt, prod;
   logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

   // Request qualification and operand magnitude extraction.
   always_comb begin
      can_start   = bus.start && !bus.flush && (state_q != MD_RUN);
      accept_iter = can_start && is_iter_op(bus.op);
      accept_mt   = can_start && ((bus.op == MD_MTHI) || (bus.op == MD_MTLO));
      last_step   = (state_q == MD_RUN) && !bus.flush && (cnt_q == CNT_W'(WIDTH - 1));
      is_mul_op   = (bus.op == MD_MULT) || (bus.op == MD_MULTU);
      a_neg       = is_signed_op(bus.op) && bus.a[WIDTH-1];
      b_neg       = is_signed_op(bus.op) && bus.b[WIDTH-1];
      abs_a       = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
      abs_b       = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
   end

   md_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept_iter),
      .step    (state_q == MD_RUN),
      .mode    (!is_mul_q),
      .lo_in   (is_mul_op ? abs_b : abs_a),
      .opd_in  (is_mul_op ? abs_a : abs_b),
      .acc_nxt (acc_nxt)
   );

   // Sign fix-up of the final step before it lands in hi/lo.
   always_comb begin
      prod = q_neg_q ? (~acc_nxt + (2*WIDTH)'(1)) : acc_nxt;
      quot = acc_nxt[WIDTH-1:0];
      rem  = acc_nxt[2*WIDTH-1:WIDTH];
      if (is_mul_q) begin
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end else begin
         res_hi = r_neg_q ? (~rem + WIDTH'(1)) : rem;
         res_lo = q_neg_q ? (~quot + WIDTH'(1)) : quot;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= MD_IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: flush always wins, FIN may chain straight into RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         MD_RUN: begin
            if (bus.flush)     state_d = MD_IDLE;
            else if (last_step) state_d = MD_FIN;
         end
         default: state_d = accept_iter ? MD_RUN : MD_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      bus.busy  = (state_q == MD_RUN);
      bus.done  = (state_q == MD_FIN);
      bus.hi    = hi_q;
      bus.lo    = lo_q;
      state_dbg = state_q;
   end

   // Step counter and result-sign flags captured on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         is_mul_q <= 1'b0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
      end else if (accept_iter) begin
         cnt_q    <= '0;
         is_mul_q <= is_mul_op;
         // A zero divisor keeps the all-ones quotient unsigned.
         q_neg_q  <= (a_neg ^ b_neg) && (is_mul_op || (bus.b != '0));
         r_neg_q  <= a_neg;
      end else if (state_q == MD_RUN) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // HI/LO change only on result write or MTHI/MTLO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (last_step) begin
         hi_q <= res_hi;
         lo_q <= res_lo;
      end else if (accept_mt) begin
         if (bus.op == MD_MTHI) hi_q <= bus.a;
         else                   lo_q <= bus.a;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32): directed cases with
// hand-derived results plus random ops checked against an arithmetic model.
module tb_mul_div_unit;
   import md_pkg::*;

   localparam int W = 32;

   logic      clk;
   logic      rst_n;
   md_state_e state_dbg;

   mul_div_unit_if #(.WIDTH(W)) bus ();

   mul_div_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [2*W-1:0] exp_q[$];
   logic [W-1:0]   hi_m, lo_m;

   // Clock and reset.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: results straight from the arithmetic definitions.
   function automatic void ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] hi_in, input logic [W-1:0] lo_in,
                                  output logic [W-1:0] hi_o, output logic [W-1:0] lo_o);
      longint         sp;
      logic [63:0]    up;
      int             sq, sr;
      hi_o = hi_in;
      lo_o = lo_in;
      case (op)
         MD_MULT: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            up = sp;
            hi_o = up[63:32];
            lo_o = up[31:0];
         end
         MD_MULTU: begin
            up = {32'b0, a} * {32'b0, b};
            hi_o = up[63:32];
            lo_o = up[31:0];
         end
         MD_DIV: begin
            if (b == 0) begin
               lo_o = '1; hi_o = a;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               lo_o = 32'h8000_0000; hi_o = '0;
            end else begin
               sq = $signed(a) / $signed(b);
               sr = $signed(a) % $signed(b);
               lo_o = sq; hi_o = sr;
            end
         end
         MD_DIVU: begin
            if (b == 0) begin
               lo_o = '1; hi_o = a;
            end else begin
               lo_o = a / b; hi_o = a % b;
            end
         end
         MD_MTHI: hi_o = a;
         MD_MTLO: lo_o = a;
         default: ;
      endcase
   endfunction

   // Driver: hold a request across exactly one rising edge.
   task automatic drive_start(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      drive_start(op, a, b);
   endtask

   // Wait for the done cycle of the oldest queued op and score it.
   task automatic collect();
      int n = 0;
      logic [2*W-1:0] e;
      @(negedge clk);
      chk("hold_hi", bus.hi, hi_m);
      chk("hold_lo", bus.lo, lo_m);
      while (bus.busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("busy_cycles", n, 32);
      chk("done", bus.done, 1'b1);
      if (exp_q.size() == 0) begin
         chk("queue_empty", 1, 0);
      end else begin
         e = exp_q.pop_front();
         chk("hi", bus.hi, e[63:32]);
         chk("lo", bus.lo, e[31:0]);
         hi_m = e[63:32];
         lo_m = e[31:0];
      end
   endtask

   task automatic exec_iter(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] ehi, input logic [W-1:0] elo);
      exp_q.push_back({ehi, elo});
      issue(op, a, b);
      collect();
      @(negedge clk);
      chk("done_one_cycle", bus.done, 1'b0);
   endtask

   task automatic exec(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] eh, el;
      ref_op(op, a, b, hi_m, lo_m, eh, el);
      if (is_iter_op(op)) begin
         exec_iter(op, a, b, eh, el);
      end else begin
         issue(op, a, b);
         @(negedge clk);
         chk("single_busy", bus.busy, 1'b0);
         chk("single_done", bus.done, 1'b0);
         chk("single_hi", bus.hi, eh);
         chk("single_lo", bus.lo, el);
         hi_m = eh;
         lo_m = el;
      end
   endtask

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a, b, ehi, elo;
   } vec_t;

   vec_t vecs[6] = '{
      '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB},
      '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
      '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD},
      '{MD_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E},
      '{MD_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF},
      '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000}
   };

   initial begin : main
      int n;
      int done_cnt;
      logic [2:0]   op;
      logic [W-1:0] ra, rb, eh, el;

      bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
      hi_m = '0; lo_m = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_hi", bus.hi, '0);
      chk("rst_lo", bus.lo, '0);
      chk("rst_state", state_dbg, MD_IDLE);
      rst_n = 1'b1;

      // Directed arithmetic cases.
      foreach (vecs[i]) exec_iter(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);

      // Flush aborts an in-flight multiply without touching hi/lo.
      exec(MD_MTHI, 32'h1234_5678, '0);
      issue(MD_MULT, 32'h0000_0005, 32'h0000_0009);
      n = 0;
      while (n < 10) begin
         @(negedge clk);
         if (bus.busy) n++;
         else begin
            chk("flush_busy_early_drop", bus.busy, 1'b1);
            n = 10;
         end
      end
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", bus.busy, 1'b0);
      done_cnt = 0;
      repeat (40) begin
         if (bus.done) done_cnt++;
         @(negedge clk);
      end
      chk("flush_no_done", done_cnt, 0);
      chk("flush_hi", bus.hi, 32'h1234_5678);
      chk("flush_lo", bus.lo, lo_m);

      // Flush in IDLE drops a simultaneous MTLO.
      @(negedge clk);
      bus.flush = 1'b1;
      drive_start(MD_MTLO, 32'h0BAD_F00D, '0);
      bus.flush = 1'b0;
      @(negedge clk);
      chk("idle_flush_lo", bus.lo, lo_m);
      chk("idle_flush_busy", bus.busy, 1'b0);

      // Starts while busy are ignored; a start in the done cycle is taken.
      ref_op(MD_MULT, 32'h0000_0011, 32'hFFFF_FFFE, hi_m, lo_m, eh, el);
      exp_q.push_back({eh, el});
      issue(MD_MULT, 32'h0000_0011, 32'hFFFF_FFFE);
      n = 0;
      @(negedge clk);
      while (bus.busy && n < 100) begin
         n++;
         bus.start = 1'b0;
         if (n == 4)  begin bus.start = 1'b1; bus.op = MD_MTLO; bus.a = 32'hDEAD_BEEF; end
         if (n == 8)  begin bus.start = 1'b1; bus.op = MD_MULT; bus.a = 32'h7; bus.b = 32'h7; end
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk("ign_busy_cycles", n, 32);
      chk("ign_done", bus.done, 1'b1);
      begin
         logic [2*W-1:0] e;
         e = exp_q.pop_front();
         chk("ign_hi", bus.hi, e[63:32]);
         chk("ign_lo", bus.lo, e[31:0]);
         hi_m = e[63:32];
         lo_m = e[31:0];
      end
      ref_op(MD_MULTU, 32'h0001_0000, 32'h0003_0000, hi_m, lo_m, eh, el);
      exp_q.push_back({eh, el});
      drive_start(MD_MULTU, 32'h0001_0000, 32'h0003_0000);
      @(negedge clk);
      chk("fin_start_busy", bus.busy, 1'b1);
      n = 1;
      while (bus.busy && n < 100) begin
         @(negedge clk);
         if (bus.busy) n++;
      end
      chk("b2b_busy_cycles", n, 32);
      chk("b2b_done", bus.done, 1'b1);
      begin
         logic [2*W-1:0] e;
         e = exp_q.pop_front();
         chk("b2b_hi", bus.hi, e[63:32]);
         chk("b2b_lo", bus.lo, e[31:0]);
         hi_m = e[63:32];
         lo_m = e[31:0];
      end

      // Asynchronous reset in the middle of a divide.
      issue(MD_DIV, 32'h0000_1234, 32'h0000_0011);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", bus.busy, 1'b0);
      chk("arst_done", bus.done, 1'b0);
      chk("arst_hi", bus.hi, '0);
      chk("arst_lo", bus.lo, '0);
      hi_m = '0; lo_m = '0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      exec_iter(MD_MULTU, 32'd2, 32'd3, 32'h0, 32'h6);

      // Random ops, including undefined codes and zero divisors.
      repeat (60) begin
         op = 3'($urandom_range(0, 7));
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = '0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
         exec(op, ra, rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
